key_expansion_ctrl_256: RTL and testbench

KEY_EXPANSION_CTRL_256 -- requirements
Module: key_expansion_ctrl_256

---
 rtl/key_expansion_ctrl_256_pkg.sv | 33 +++
 rtl/key_expansion_ctrl_256_word_gen.sv | 56 +++++
 rtl/key_expansion_ctrl_256.sv | 98 +++++++++
 tb/tb_key_expansion_ctrl_256.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/key_expansion_ctrl_256_pkg.sv
// Shared AES-256 key-schedule constants.
//   NK, NWORDS  : key length in words and total expanded words
//   kx_state_t  : controller state encoding
//   rcon()      : round constant byte selected by i[5:3]
package key_expansion_ctrl_256_pkg;

    localparam int NK     = 8;
    localparam int NWORDS = 60;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_EXPAND = 2'd2,
        ST_DONE   = 2'd3
    } kx_state_t;

    // Only indices 1..7 are reached: the first rotated word is w[8].
    function automatic logic [7:0] rcon(input logic [2:0] r);
        logic [7:0] v;
        case (r)
            3'd1:    v = 8'h01;
            3'd2:    v = 8'h02;
            3'd3:    v = 8'h04;
            3'd4:    v = 8'h08;
            3'd5:    v = 8'h10;
            3'd6:    v = 8'h20;
            3'd7:    v = 8'h40;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/key_expansion_ctrl_256_word_gen.sv
// Combinational AES-256 next-word generator.
//   i                : index of the word being produced (8..59)
//   prev_word        : w[i-1]
//   prev_period_word : w[i-8]
//   word             : w[i]
module current_word_gen_256
    import key_expansion_ctrl_256_pkg::*;
(
    input  logic [5:0]  i,
    input  logic [31:0] prev_word,
    input  logic [31:0] prev_period_word,
    output logic [31:0] word
);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 sits in the top byte, so byte x lives at bit offset (255-x)*8.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    logic [31:0] temp;

    always_comb begin
        temp = prev_word;
        if (i[2:0] == 3'd0) begin
            temp = sub_word({prev_word[23:0], prev_word[31:24]}) ^ {rcon(i[5:3]), 24'h0};
        end else if (i[2:0] == 3'd4) begin
            // AES-256 extra substitution halfway through each 8-word period
            temp = sub_word(prev_word);
        end
        word = prev_period_word ^ temp;
    end

endmodule

// File: rtl/key_expansion_ctrl_256.sv
// AES-256 key-expansion controller: captures a 256-bit key on start and
// streams the 60 expanded words, one per cycle, to a key memory.
//   clk, rst      : clock, synchronous active-high reset
//   start, key    : expansion request and cipher key (w[0] in key[255:224])
//   busy, done    : expansion in progress / one-cycle completion pulse
//   wr_en/addr/data : key-memory write port, w[wr_addr]
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | writing w[0..7] straight from the captured key
// EXPAND | generating and writing w[8..59]
// DONE   | one-cycle done pulse, no write
module key_expansion_ctrl_256 #(
    parameter int NK     = key_expansion_ctrl_256_pkg::NK,
    parameter int NWORDS = key_expansion_ctrl_256_pkg::NWORDS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] key,
    output logic         busy,
    output logic         done,
    output logic         wr_en,
    output logic [5:0]   wr_addr,
    output logic [31:0]  wr_data
);
    import key_expansion_ctrl_256_pkg::*;

    kx_state_t        state;
    logic [5:0]       word_idx;
    logic [255:0]     key_q;
    // window[0] is the newest word w[i-1], window[7] the oldest w[i-8]
    logic [7:0][31:0] window;
    logic [2:0]       load_sel;
    logic [31:0]      load_word;
    logic [31:0]      gen_word;

    assign load_sel  = 3'd7 - word_idx[2:0];
    assign load_word = key_q[{load_sel, 5'd0} +: 32];

    current_word_gen_256 u_word_gen (
        .i                (word_idx),
        .prev_word        (window[0]),
        .prev_period_word (window[7]),
        .word             (gen_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            word_idx <= '0;
            key_q    <= '0;
            window   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        key_q    <= key;
                        word_idx <= '0;
                        state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    window   <= {window[6:0], load_word};
                    word_idx <= word_idx + 6'd1;
                    if (word_idx == 6'(NK - 1)) state <= ST_EXPAND;
                end
                ST_EXPAND: begin
                    window <= {window[6:0], gen_word};
                    // hold at the last index so the counter never passes 59
                    if (word_idx == 6'(NWORDS - 1)) begin
                        state <= ST_DONE;
                    end else begin
                        word_idx <= word_idx + 6'd1;
                    end
                end
                ST_DONE: begin
                    word_idx <= '0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs depend on registered state only; start never reaches them.
    assign busy    = (state == ST_LOAD) || (state == ST_EXPAND);
    assign wr_en   = busy;
    assign done    = (state == ST_DONE);
    assign wr_addr = wr_en ? word_idx : 6'd0;

    always_comb begin
        wr_data = '0;
        if (state == ST_LOAD)   wr_data = load_word;
        if (state == ST_EXPAND) wr_data = gen_word;
    end

endmodule

// File: tb/tb_key_expansion_ctrl_256.sv
module tb_key_expansion_ctrl_256;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [255:0] key;
    logic         busy;
    logic         done;
    logic         wr_en;
    logic [5:0]   wr_addr;
    logic [31:0]  wr_data;

    always #5 clk = ~clk;

    key_expansion_ctrl_256 #(.NK(8), .NWORDS(60)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .key     (key),
        .busy    (busy),
        .done    (done),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    localparam logic [255:0] KEY_A3 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          wr_cnt   = 0;
    int          done_cnt = 0;
    int          exp_addr = 0;
    logic [31:0] got [0:59];
    int          start_cycs[$];
    int          done_cycs[$];
    int          t0;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: logs every write and done pulse, checks address order.
    always @(negedge clk) begin
        cyc++;
        if (wr_en) begin
            chk_val("wr_addr_seq", 32'(wr_addr), 32'(exp_addr));
            if (wr_addr == 6'd0) start_cycs.push_back(cyc);
            if (wr_addr < 6'd60) got[wr_addr] = wr_data;
            exp_addr = (exp_addr == 59) ? 0 : exp_addr + 1;
            wr_cnt++;
        end
        if (done) begin
            done_cnt++;
            done_cycs.push_back(cyc);
            chk_val("done_busy_low", 32'(busy), 32'd0);
        end
    end

    // Call only at posedge+1 to stay clear of the scoreboard.
    task automatic sb_clear();
        wr_cnt   = 0;
        done_cnt = 0;
        exp_addr = 0;
        start_cycs.delete();
        done_cycs.delete();
        for (int j = 0; j < 60; j++) got[j] = 32'hdeadbeef;
    endtask

    // Called at posedge+1; returns t0 such that cycle k's negedge has cyc == t0+k.
    task automatic pulse_start(output int t);
        start = 1'b1;
        t = cyc + 1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic check_single_run(input string pfx, input int t);
        chk_val({pfx, "_wr_count"}, 32'(wr_cnt), 32'd60);
        chk_val({pfx, "_done_count"}, 32'(done_cnt), 32'd1);
        chk_val({pfx, "_first_wr_cycle"}, 32'((start_cycs.size() > 0) ? start_cycs[0] - t : -1), 32'd1);
        chk_val({pfx, "_done_cycle"}, 32'((done_cycs.size() > 0) ? done_cycs[0] - t : -1), 32'd61);
    endtask

    task automatic check_a3_words(input string pfx);
        logic [255:0] k;
        int          a_addr [7];
        logic [31:0] a_val  [7];
        k      = KEY_A3;
        a_addr = '{8, 9, 10, 11, 12, 56, 59};
        a_val  = '{32'h9ba35411, 32'h8e6925af, 32'ha51a8b5f, 32'h2067fcde,
                   32'ha8b09c1a, 32'hfe4890d1, 32'h706c631e};
        for (int j = 0; j < 8; j++)
            chk_val($sformatf("%s_w%0d", pfx, j), got[j], k[255 - 32*j -: 32]);
        for (int j = 0; j < 7; j++)
            chk_val($sformatf("%s_w%0d", pfx, a_addr[j]), got[a_addr[j]], a_val[j]);
    endtask

    task automatic check_zero_words(input string pfx);
        for (int j = 0; j < 8; j++)
            chk_val($sformatf("%s_w%0d", pfx, j), got[j], 32'h00000000);
        for (int j = 8; j < 12; j++)
            chk_val($sformatf("%s_w%0d", pfx, j), got[j], 32'h62636363);
        for (int j = 12; j < 16; j++)
            chk_val($sformatf("%s_w%0d", pfx, j), got[j], 32'haafbfbfb);
        chk_val({pfx, "_w16"}, got[16], 32'h6f6c6ccf);
    endtask

    initial begin
        for (int j = 0; j < 60; j++) got[j] = 32'hdeadbeef;

        // Reset with start high: reset wins, outputs cleared
        rst   = 1'b1;
        start = 1'b1;
        key   = KEY_A3;
        repeat (3) @(posedge clk);
        #1;
        chk_val("rst_busy",    32'(busy),    32'd0);
        chk_val("rst_done",    32'(done),    32'd0);
        chk_val("rst_wr_en",   32'(wr_en),   32'd0);
        chk_val("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk_val("rst_wr_data", wr_data,      32'd0);
        rst   = 1'b0;
        start = 1'b0;
        sb_clear();
        repeat (3) @(posedge clk);
        #1;
        chk_val("idle_busy",   32'(busy),   32'd0);
        chk_val("idle_writes", 32'(wr_cnt), 32'd0);

        // FIPS-197 A.3 expansion
        sb_clear();
        key = KEY_A3;
        pulse_start(t0);
        repeat (63) @(posedge clk);
        #1;
        check_single_run("a3", t0);
        check_a3_words("a3");

        // All-zero key
        sb_clear();
        key = '0;
        pulse_start(t0);
        repeat (63) @(posedge clk);
        #1;
        check_single_run("zero", t0);
        check_zero_words("zero");

        // Key scrambled while the A.3 expansion runs
        sb_clear();
        key = KEY_A3;
        pulse_start(t0);
        for (int c = 0; c < 63; c++) begin
            key = {$urandom, $urandom, $urandom, $urandom,
                   $urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            #1;
        end
        check_single_run("keychg", t0);
        check_a3_words("keychg");

        // start held high for 100 cycles: exactly two back-to-back expansions
        sb_clear();
        key   = KEY_A3;
        start = 1'b1;
        t0    = cyc + 1;
        repeat (100) @(posedge clk);
        #1;
        start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk_val("hold_wr_count",   32'(wr_cnt),   32'd120);
        chk_val("hold_done_count", 32'(done_cnt), 32'd2);
        chk_val("hold_start_count", 32'(start_cycs.size()), 32'd2);
        chk_val("hold_first_wr1", 32'((start_cycs.size() > 0) ? start_cycs[0] - t0 : -1), 32'd1);
        chk_val("hold_first_wr2", 32'((start_cycs.size() > 1) ? start_cycs[1] - t0 : -1), 32'd63);
        chk_val("hold_done1", 32'((done_cycs.size() > 0) ? done_cycs[0] - t0 : -1), 32'd61);
        chk_val("hold_done2", 32'((done_cycs.size() > 1) ? done_cycs[1] - t0 : -1), 32'd123);
        check_a3_words("hold");

        // Reset during cycle 30 aborts the expansion
        sb_clear();
        key = KEY_A3;
        pulse_start(t0);
        repeat (29) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_val("abort_wr_en", 32'(wr_en), 32'd0);
        chk_val("abort_busy",  32'(busy),  32'd0);
        rst = 1'b0;
        repeat (70) @(posedge clk);
        #1;
        chk_val("abort_wr_count",   32'(wr_cnt),   32'd30);
        chk_val("abort_done_count", 32'(done_cnt), 32'd0);

        // Fresh start after the abort
        sb_clear();
        key = '0;
        pulse_start(t0);
        repeat (63) @(posedge clk);
        #1;
        check_single_run("fresh", t0);
        check_zero_words("fresh");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
